imm_ext_unit: RTL and testbench
===============================

// Module: imm_ext_unit
// PURPOSE
//  Immediate-field extender for the instruction decode path.
//  - Selects one of three immediate fields by format code B: AOI 4-bit, branch 8-bit, jump 12-bit.
//  - Sign- or zero-extends the selected field to 16 bits and registers it, so the execute stage
//    receives a timing-clean operand one cycle later.
//  - Flags the reserved format code B=2'b11.
// PARAMETERS
//  OUT_W   16  width of extended output
//  AOI_W    4  width of tb (AOI immediate)
//  BR_W     8  width of tc (branch offset)
//  JMP_W   12  width of td (jump target/offset); all field widths must be < OUT_W
// PORTS
//  clk      in   1       single clock; all state updates on rising edge
//  rst      in   1       synchronous, active-high reset
//  tb       in   AOI_W   AOI immediate field
//  tc       in   BR_W    branch immediate field
//  td       in   JMP_W   jump immediate field
//  B        in   2       format select: 00=AOI(tb) 01=branch(tc) 10=jump(td) 11=reserved
//  sz       in   1       1=sign-extend (replicate field MSB), 0=zero-extend
//  out      out  OUT_W   registered extended immediate
//  illegal  out  1       registered flag, 1 when sampled B==2'b11
// BEHAVIOUR
//  - Clocking: one clock domain (clk). Reset is synchronous and active-high (rst).
//  - Latency: exactly 1 cycle. Inputs sampled at edge N appear on out/illegal after edge N.
//  - No enable, no handshake: a new result is registered every cycle.
//  - Reset: on any edge with rst=1, out<=0 and illegal<=0, regardless of other inputs.
//    Reset has priority over every computation, including mid-stream.
//  - Extension: ext = sz ? {{(OUT_W-W){f[W-1]}}, f} : {{(OUT_W-W){1'b0}}, f},
//    where f is the field selected by B and W is its width.
//  - B=00: out <= ext(tb), illegal <= 0.
//  - B=01: out <= ext(tc), illegal <= 0.
//  - B=10: out <= ext(td), illegal <= 0.
//  - B=11: out <= 0, illegal <= 1. The flag is not sticky; it clears on the next legal B.
//  - Unselected fields are ignored entirely. No arithmetic beyond extension: no shift, no PC add.
//  - X or Z on B: treat as reserved (out <= 0, illegal <= 1). Synthesis default branch = reserved.
//  - No internal state other than the two output registers.
// STRUCTURE
//  - Shared package imm_ext_pkg:
//    - localparams FMT_AOI=2'b00, FMT_BR=2'b01, FMT_JMP=2'b10, FMT_RSV=2'b11.
//    - Default widths OUT_W, AOI_W, BR_W, JMP_W.
//  - Sub-module imm_extend #(IN_W, OUT_W) (f, sz -> ext): purely combinational.
//    Instantiate it three times (one per field width).
//  - Top level: case-mux on B, then output register with synchronous reset.
// TESTING
//  1. rst=1 for 2 cycles, B=10, td=12'hFFF, sz=1 -> out=16'h0000, illegal=0.
//  2. B=00, tb=4'h0, sz=0 -> out=16'h0000.
//     tb=4'h9, sz=1 -> 16'hFFF9.
//     tb=4'h9, sz=0 -> 16'h0009.
//  3. B=01, tc=8'h11 -> 16'h0011 for both sz values.
//     tc=8'h80, sz=1 -> 16'hFF80.
//     tc=8'h80, sz=0 -> 16'h0080.
//  4. B=10, td=12'h010 -> 16'h0010.
//     td=12'h800, sz=1 -> 16'hF800.
//     td=12'h800, sz=0 -> 16'h0800.
//  5. B=11, any fields -> out=16'h0000, illegal=1.
//     Next cycle B=00, tb=4'h1 -> out=16'h0001, illegal=0.
//  6. Latency/back-to-back: change B/fields every cycle and check each result appears exactly 1 edge later.
//     Assert rst mid-stream -> out=0 on that edge.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate extender.
//   FMT_*       : format-select encodings on B
//   DEF_*_W     : default output and field widths
package imm_ext_pkg;

    localparam logic [1:0] FMT_AOI = 2'b00;
    localparam logic [1:0] FMT_BR  = 2'b01;
    localparam logic [1:0] FMT_JMP = 2'b10;
    localparam logic [1:0] FMT_RSV = 2'b11;

    localparam int DEF_OUT_W = 16;
    localparam int DEF_AOI_W = 4;
    localparam int DEF_BR_W  = 8;
    localparam int DEF_JMP_W = 12;

endpackage

// File: rtl/imm_extend.sv
// Combinational sign/zero extender for one immediate field.
//   f   in  IN_W   field to extend
//   sz  in  1      1 = replicate f MSB, 0 = pad with zeros
//   ext out OUT_W  extended field
// IN_W must be strictly less than OUT_W.
module imm_extend #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  f,
    input  logic             sz,
    output logic [OUT_W-1:0] ext
);

    logic pad;

    assign pad = sz & f[IN_W-1];
    assign ext = {{(OUT_W-IN_W){pad}}, f};

endmodule

// File: rtl/imm_ext_unit.sv
// Immediate-field extender for the decode path. Selects one of three
// immediate fields by format code B, extends it to OUT_W bits and registers
// the result so execute sees it exactly one cycle later.
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous active-high reset
//   tb       in   AOI_W  AOI immediate          (B=00)
//   tc       in   BR_W   branch immediate       (B=01)
//   td       in   JMP_W  jump immediate         (B=10)
//   B        in   2      format select, 11 = reserved
//   sz       in   1      1 = sign-extend, 0 = zero-extend
//   out      out  OUT_W  registered extended immediate
//   illegal  out  1      registered reserved-format flag
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int AOI_W = DEF_AOI_W,
    parameter int BR_W  = DEF_BR_W,
    parameter int JMP_W = DEF_JMP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AOI_W-1:0] tb,
    input  logic [BR_W-1:0]  tc,
    input  logic [JMP_W-1:0] td,
    input  logic [1:0]       B,
    input  logic             sz,
    output logic [OUT_W-1:0] out,
    output logic             illegal
);

    logic [OUT_W-1:0] ext_aoi, ext_br, ext_jmp;
    logic [OUT_W-1:0] out_d, out_q;
    logic             illegal_d, illegal_q;

    imm_extend #(.IN_W(AOI_W), .OUT_W(OUT_W)) u_ext_aoi (.f(tb), .sz(sz), .ext(ext_aoi));
    imm_extend #(.IN_W(BR_W),  .OUT_W(OUT_W)) u_ext_br  (.f(tc), .sz(sz), .ext(ext_br));
    imm_extend #(.IN_W(JMP_W), .OUT_W(OUT_W)) u_ext_jmp (.f(td), .sz(sz), .ext(ext_jmp));

    // Anything that is not a legal format (including X/Z in simulation)
    // falls to the default arm and is flagged as reserved with a zero operand.
    always_comb begin
        out_d     = '0;
        illegal_d = 1'b0;
        case (B)
            FMT_AOI: out_d = ext_aoi;
            FMT_BR:  out_d = ext_br;
            FMT_JMP: out_d = ext_jmp;
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            illegal_q <= illegal_d;
        end
    end

    assign out     = out_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed-vector bench for imm_ext_unit. Each vector is applied just after
// a rising edge; the registered result is checked 1 time unit after the
// following edge, and the previous result is checked to still be held
// before that edge (exactly one cycle of latency).
module tb_imm_ext_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  tb;
    logic [7:0]  tc;
    logic [11:0] td;
    logic [1:0]  B;
    logic        sz;
    logic [15:0] out;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    logic [15:0] prev_out;
    logic        prev_ill;
    logic        prev_vld = 1'b0;

    always #5 clk = ~clk;

    imm_ext_unit dut (
        .clk(clk), .rst(rst), .tb(tb), .tc(tc), .td(td),
        .B(B), .sz(sz), .out(out), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one vector, confirm the old result is still held, step one edge,
    // then check the new registered result.
    task automatic apply(input string tag, input logic r, input logic [1:0] b,
                         input logic [3:0] t4, input logic [7:0] t8,
                         input logic [11:0] t12, input logic s,
                         input logic [15:0] eo, input logic eil);
        rst = r; B = b; tb = t4; tc = t8; td = t12; sz = s;
        #1;
        if (prev_vld) begin
            chk({tag, "_hold_out"}, {16'h0, out}, {16'h0, prev_out});
            chk({tag, "_hold_ill"}, {31'h0, illegal}, {31'h0, prev_ill});
        end
        @(posedge clk);
        #1;
        chk({tag, "_out"}, {16'h0, out}, {16'h0, eo});
        chk({tag, "_ill"}, {31'h0, illegal}, {31'h0, eil});
        prev_out = eo;
        prev_ill = eil;
        prev_vld = 1'b1;
    endtask

    initial begin
        rst = 1'b1; B = 2'b10; tb = 4'h0; tc = 8'h00; td = 12'hFFF; sz = 1'b1;
        @(posedge clk); #1;

        // reset dominates a sign-extending jump vector
        apply("rst0", 1'b1, 2'b10, 4'h0, 8'h00, 12'hFFF, 1'b1, 16'h0000, 1'b0);
        apply("rst1", 1'b1, 2'b10, 4'h0, 8'h00, 12'hFFF, 1'b1, 16'h0000, 1'b0);

        // AOI; unselected fields carry junk that must be ignored
        apply("aoi0",  1'b0, 2'b00, 4'h0, 8'hFF, 12'hFFF, 1'b0, 16'h0000, 1'b0);
        apply("aoi9s", 1'b0, 2'b00, 4'h9, 8'hA5, 12'h5A5, 1'b1, 16'hFFF9, 1'b0);
        apply("aoi9z", 1'b0, 2'b00, 4'h9, 8'hA5, 12'h5A5, 1'b0, 16'h0009, 1'b0);
        apply("aoi7s", 1'b0, 2'b00, 4'h7, 8'h80, 12'h800, 1'b1, 16'h0007, 1'b0);

        // branch
        apply("br11s", 1'b0, 2'b01, 4'hF, 8'h11, 12'hFFF, 1'b1, 16'h0011, 1'b0);
        apply("br11z", 1'b0, 2'b01, 4'hF, 8'h11, 12'hFFF, 1'b0, 16'h0011, 1'b0);
        apply("br80s", 1'b0, 2'b01, 4'h0, 8'h80, 12'h000, 1'b1, 16'hFF80, 1'b0);
        apply("br80z", 1'b0, 2'b01, 4'h0, 8'h80, 12'h000, 1'b0, 16'h0080, 1'b0);

        // jump
        apply("jmp10",  1'b0, 2'b10, 4'hF, 8'hFF, 12'h010, 1'b1, 16'h0010, 1'b0);
        apply("jmp800s",1'b0, 2'b10, 4'h0, 8'h00, 12'h800, 1'b1, 16'hF800, 1'b0);
        apply("jmp800z",1'b0, 2'b10, 4'h0, 8'h00, 12'h800, 1'b0, 16'h0800, 1'b0);
        apply("jmpFFFs",1'b0, 2'b10, 4'h0, 8'h00, 12'hFFF, 1'b1, 16'hFFFF, 1'b0);

        // reserved, then flag clears on the next legal format
        apply("rsv0", 1'b0, 2'b11, 4'hF, 8'hFF, 12'hFFF, 1'b1, 16'h0000, 1'b1);
        apply("rsv1", 1'b0, 2'b11, 4'h9, 8'h80, 12'h800, 1'b0, 16'h0000, 1'b1);
        apply("aoi1", 1'b0, 2'b00, 4'h1, 8'h00, 12'h000, 1'b0, 16'h0001, 1'b0);

        // back-to-back format changes with mid-stream resets
        apply("b2b0", 1'b0, 2'b01, 4'h0, 8'hC3, 12'h000, 1'b1, 16'hFFC3, 1'b0);
        apply("b2b1", 1'b0, 2'b10, 4'h0, 8'h00, 12'h7FF, 1'b1, 16'h07FF, 1'b0);
        apply("mrst", 1'b1, 2'b01, 4'h0, 8'h80, 12'h000, 1'b1, 16'h0000, 1'b0);
        apply("b2b2", 1'b0, 2'b00, 4'h8, 8'h00, 12'h000, 1'b1, 16'hFFF8, 1'b0);
        apply("mrsv", 1'b1, 2'b11, 4'hF, 8'hFF, 12'hFFF, 1'b1, 16'h0000, 1'b0);
        apply("b2b3", 1'b0, 2'b11, 4'h0, 8'h00, 12'h000, 1'b0, 16'h0000, 1'b1);
        apply("b2b4", 1'b0, 2'b10, 4'h0, 8'h00, 12'hA5A, 1'b1, 16'hFA5A, 1'b0);
        apply("b2b5", 1'b0, 2'b01, 4'h0, 8'h7F, 12'h000, 1'b1, 16'h007F, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
